// File: rtl/lcd_window_sequencer.sv
// lcd_window_sequencer: emits CASET/PASET/RAMWR commands and RGB565 pixel bytes for a window.
// Optional macro LCD_TE_SYNC_EN adds the te port and holds RAMWR until a te rising edge.
module lcd_window_sequencer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [15:0] px_data,
    input  logic        px_valid,
    output logic        px_ready,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        byte_valid,
    input  logic        byte_ready
`ifdef LCD_TE_SYNC_EN
    ,
    input  logic        te
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CASET   = 3'd1;
    localparam logic [2:0] PASET   = 3'd2;
`ifdef LCD_TE_SYNC_EN
    localparam logic [2:0] WAIT_TE = 3'd3;
`endif
    localparam logic [2:0] RAMWR   = 3'd4;
    localparam logic [2:0] PIX_HI  = 3'd5;
    localparam logic [2:0] PIX_LO  = 3'd6;
    localparam logic [2:0] FINISH  = 3'd7;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
    localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [16:0] n_q, n_d;
    logic [8:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_dc_q, byte_dc_d;
    logic        byte_valid_q, byte_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        xfer_s;
    logic        can_load_s;
    logic        win_ok_s;
    logic [16:0] w_s, h_s, pix_count_s;

    // Argument byte idx (1..4) of a big-endian 16-bit start/end pair, 9-bit coords zero-extended
    function automatic logic [7:0] arg_byte(input logic [2:0] idx, input logic [8:0] lo_v,
                                            input logic [8:0] hi_v);
        logic [7:0] b;
        case (idx)
            3'd1:    b = {7'd0, lo_v[8]};
            3'd2:    b = lo_v[7:0];
            3'd3:    b = {7'd0, hi_v[8]};
            3'd4:    b = hi_v[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign xfer_s      = byte_valid_q & byte_ready;
    assign can_load_s  = ~byte_valid_q | byte_ready;
    assign win_ok_s    = (x0 <= x1) && ({1'b0, x1} < WIDTH_L) &&
                         (y0 <= y1) && ({1'b0, y1} < HEIGHT_L);
    assign w_s         = {8'd0, x1_q} - {8'd0, x0_q} + 17'd1;
    assign h_s         = {8'd0, y1_q} - {8'd0, y0_q} + 17'd1;
    assign pix_count_s = w_s * h_s;

`ifdef LCD_TE_SYNC_EN
    logic te_sync1_q, te_sync2_q, te_prev_q;
    logic te_rise_s;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection of te
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            te_sync1_q <= 1'b0;
            te_sync2_q <= 1'b0;
            te_prev_q  <= 1'b0;
        end else begin
            te_sync1_q <= te;
            te_sync2_q <= te_sync1_q;
            te_prev_q  <= te_sync2_q;
        end
    end

    assign te_rise_s = te_sync2_q & ~te_prev_q;
`endif

    // Next-state logic: a new byte is loaded whenever the output slot is free or being emptied
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y0_d         = y0_q;
        y1_d         = y1_q;
        lo_d         = lo_q;
        byte_data_d  = byte_data_q;
        byte_dc_d    = byte_dc_q;
        byte_valid_d = byte_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (win_ok_s) begin
                        x0_d    = x0;
                        x1_d    = x1;
                        y0_d    = y0;
                        y1_d    = y1;
                        idx_d   = 3'd0;
                        busy_d  = 1'b1;
                        state_d = CASET;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CASET: begin
                if (can_load_s) begin
                    byte_valid_d = 1'b1;
                    if (idx_q == 3'd5) begin
                        byte_data_d = CMD_PASET;
                        byte_dc_d   = 1'b0;
                        idx_d       = 3'd1;
                        state_d     = PASET;
                    end else if (idx_q == 3'd0) begin
                        byte_data_d = CMD_CASET;
                        byte_dc_d   = 1'b0;
                        idx_d       = 3'd1;
                    end else begin
                        byte_data_d = arg_byte(idx_q, x0_q, x1_q);
                        byte_dc_d   = 1'b1;
                        idx_d       = idx_q + 3'd1;
                    end
                end else begin
                    state_d = CASET;
                end
            end
            PASET: begin
                if (can_load_s) begin
                    if (idx_q == 3'd5) begin
`ifdef LCD_TE_SYNC_EN
                        byte_valid_d = 1'b0;
                        state_d      = WAIT_TE;
`else
                        byte_valid_d = 1'b1;
                        byte_data_d  = CMD_RAMWR;
                        byte_dc_d    = 1'b0;
                        n_d          = pix_count_s;
                        state_d      = RAMWR;
`endif
                    end else begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = arg_byte(idx_q, y0_q, y1_q);
                        byte_dc_d    = 1'b1;
                        idx_d        = idx_q + 3'd1;
                    end
                end else begin
                    state_d = PASET;
                end
            end
`ifdef LCD_TE_SYNC_EN
            WAIT_TE: begin
                if (te_rise_s) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = CMD_RAMWR;
                    byte_dc_d    = 1'b0;
                    n_d          = pix_count_s;
                    state_d      = RAMWR;
                end else begin
                    state_d = WAIT_TE;
                end
            end
`endif
            RAMWR: begin
                if (xfer_s) begin
                    byte_valid_d = 1'b0;
                    state_d      = PIX_HI;
                end else begin
                    state_d = RAMWR;
                end
            end
            PIX_HI: begin
                if (!byte_valid_q) begin
                    if (px_valid) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = px_data[15:8];
                        byte_dc_d    = 1'b1;
                        lo_d         = px_data[7:0];
                    end else begin
                        state_d = PIX_HI;
                    end
                end else if (xfer_s) begin
                    byte_data_d = lo_q;
                    state_d     = PIX_LO;
                end else begin
                    state_d = PIX_HI;
                end
            end
            PIX_LO: begin
                if (xfer_s) begin
                    byte_valid_d = 1'b0;
                    n_d          = n_q - 17'd1;
                    if (n_q == 17'd1) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = PIX_HI;
                    end
                end else begin
                    state_d = PIX_LO;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                byte_valid_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any window in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            n_q          <= 17'd0;
            x0_q         <= 9'd0;
            x1_q         <= 9'd0;
            y0_q         <= 9'd0;
            y1_q         <= 9'd0;
            lo_q         <= 8'h00;
            byte_data_q  <= 8'h00;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            y0_q         <= y0_d;
            y1_q         <= y1_d;
            lo_q         <= lo_d;
            byte_data_q  <= byte_data_d;
            byte_dc_q    <= byte_dc_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;
    assign byte_valid = byte_valid_q;
    assign px_ready   = (state_q == PIX_HI) && !byte_valid_q;

endmodule
